// File: rtl/rbus_pkg.sv
// Ring-bus shared types and slot constants.
// Used by the frame generator and the receive-side frame checker.
package rbus_pkg;

    localparam int RSBUS_SHORT_LEN = 2;
    localparam int RSBUS_LONG_LEN  = 9;
    localparam int RSBUS_PERIOD    = RSBUS_SHORT_LEN + RSBUS_LONG_LEN;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } rsbus_chk_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] dst;
        logic [2:0] op;
    } rbus_ctrl_t;

    // Flag fields sit in the top five bits of the header.
    typedef struct packed {
        logic       frm_used;
        logic       frm_owned;
        logic [1:0] frm_priority;
        logic       frm_len;
        logic [3:0] frm_src;
        logic [6:0] frm_tag;
    } rbus_hdr_t;

    typedef struct packed {
        rbus_hdr_t header;
    } rbus_word_t;

endpackage

// File: rtl/rsbus_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async active-low), clr, inc, q.
module rsbus_sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // clr together with inc loads 1: restart counting on this event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= W'(inc);
        end else if (inc && !(&q)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/rsbus_frame_checker.sv
// Ring-bus receive frame checker: locks onto the 2+9 slot pattern.
// Ports: clk, rst, i_sof/i_ctrl/i_bus in; registered copy, timing, lock, errors out.
module rsbus_frame_checker
    import rbus_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sof,
    input  rbus_ctrl_t       i_ctrl,
    input  rbus_word_t       i_bus,
    output logic             o_sof,
    output rbus_ctrl_t       o_ctrl,
    output rbus_word_t       o_bus,
    output logic             o_hdr_stb,
    output logic             o_frm_len,
    output logic [3:0]       o_word_idx,
    output logic             o_locked,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_cnt
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam logic [3:0] SHORT_LAST = 4'(RSBUS_SHORT_LEN - 1);
    localparam logic [3:0] LONG_LAST  = 4'(RSBUS_LONG_LEN - 1);

    rsbus_chk_state_t state;
    logic             len;
    logic [3:0]       idx;
    logic [GW-1:0]    good_q;
    logic [BW-1:0]    bad_q;

    logic active, due, early, miss, lenv, good_sof, err;
    logic lock_hit, unlock_hit;
    logic good_clr, good_inc, bad_clr, bad_inc;

    logic        ctrl_vld_q;
    logic [6:0]  ctrl_dp_q;
    logic [4:0]  flags_q;
    logic [10:0] hdr_dp_q;

    // idx/len describe the word registered last cycle, so they
    // double as the aligned o_word_idx/o_frm_len outputs.
    always_comb begin
        active     = (state != HUNT);
        due        = (idx == (len ? LONG_LAST : SHORT_LAST));
        early      = active && i_sof && !due;
        miss       = active && due && !i_sof;
        lenv       = active && due && i_sof &&
                     (i_bus.header.frm_len == len);
        good_sof   = active && due && i_sof &&
                     (i_bus.header.frm_len != len);
        err        = early || miss || lenv;
        lock_hit   = (state == CHECK) && good_sof &&
                     (good_q == GW'(LOCK_CNT - 1));
        unlock_hit = (state == LOCKED) && err &&
                     (bad_q == BW'(UNLOCK_CNT - 1));
        good_clr   = (state != CHECK) || err;
        good_inc   = i_sof && ((state == HUNT) ||
                     ((state == CHECK) && (good_sof || early)));
        bad_clr    = (state != LOCKED) || good_sof;
        bad_inc    = (state == LOCKED) && err && !unlock_hit;
    end

    rsbus_sat_counter #(.W(GW)) u_good (
        .clk (clk),
        .rst (rst),
        .clr (good_clr),
        .inc (good_inc),
        .q   (good_q)
    );

    rsbus_sat_counter #(.W(BW)) u_bad (
        .clk (clk),
        .rst (rst),
        .clr (bad_clr),
        .inc (bad_inc),
        .q   (bad_q)
    );

    rsbus_sat_counter #(.W(ERR_W)) u_err (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (err),
        .q   (o_err_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            idx        <= '0;
            len        <= 1'b0;
            o_sof      <= 1'b0;
            o_hdr_stb  <= 1'b0;
            o_err      <= 1'b0;
            ctrl_vld_q <= 1'b0;
            flags_q    <= '0;
        end else begin
            o_sof      <= i_sof;
            o_hdr_stb  <= good_sof &&
                          ((state == LOCKED) || lock_hit);
            o_err      <= err;
            ctrl_vld_q <= i_ctrl.valid;
            flags_q    <= i_bus[15:11];
            unique case (state)
                HUNT: begin
                    idx <= '0;
                    len <= i_sof && i_bus.header.frm_len;
                    if (i_sof) state <= CHECK;
                end
                CHECK: begin
                    if (good_sof || early) begin
                        idx <= '0;
                        len <= i_bus.header.frm_len;
                        if (lock_hit) state <= LOCKED;
                    end else if (err) begin
                        state <= HUNT;
                        idx   <= '0;
                        len   <= 1'b0;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                LOCKED: begin
                    // Flywheel: boundary follows the expected pattern.
                    if (due) begin
                        idx <= '0;
                        len <= !len;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                    if (unlock_hit) state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

    // Payload fields carry no reset.
    always_ff @(posedge clk) begin
        ctrl_dp_q <= i_ctrl[6:0];
        hdr_dp_q  <= i_bus[10:0];
    end

    assign o_ctrl     = {ctrl_vld_q, ctrl_dp_q};
    assign o_bus      = {flags_q, hdr_dp_q};
    assign o_frm_len  = len;
    assign o_word_idx = idx;
    assign o_locked   = (state == LOCKED);

endmodule

// File: tb/tb_rsbus_frame_checker.sv
// Bench for rsbus_frame_checker: directed slot faults plus random faults.
// Reference model tracks absolute frame start times, not a word counter.
module tb_rsbus_frame_checker;
    import rbus_pkg::*;

    localparam int LOCK   = 4;
    localparam int UNLOCK = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_sof = 1'b0;
    rbus_ctrl_t i_ctrl = '0;
    rbus_word_t i_bus = '0;

    logic        o_sof, o_hdr_stb, o_frm_len, o_locked, o_err;
    rbus_ctrl_t  o_ctrl;
    rbus_word_t  o_bus;
    logic [3:0]  o_word_idx;
    logic [15:0] o_err_cnt;

    logic        s_sof, s_hdr_stb, s_frm_len, s_locked, s_err;
    rbus_ctrl_t  s_ctrl;
    rbus_word_t  s_bus;
    logic [3:0]  s_word_idx;
    logic [1:0]  s_err_cnt;

    rsbus_frame_checker #(
        .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .ERR_W(16)
    ) dut (
        .clk(clk), .rst(rst), .i_sof(i_sof), .i_ctrl(i_ctrl),
        .i_bus(i_bus), .o_sof(o_sof), .o_ctrl(o_ctrl),
        .o_bus(o_bus), .o_hdr_stb(o_hdr_stb),
        .o_frm_len(o_frm_len), .o_word_idx(o_word_idx),
        .o_locked(o_locked), .o_err(o_err),
        .o_err_cnt(o_err_cnt)
    );

    rsbus_frame_checker #(
        .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .ERR_W(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .i_sof(i_sof), .i_ctrl(i_ctrl),
        .i_bus(i_bus), .o_sof(s_sof), .o_ctrl(s_ctrl),
        .o_bus(s_bus), .o_hdr_stb(s_hdr_stb),
        .o_frm_len(s_frm_len), .o_word_idx(s_word_idx),
        .o_locked(s_locked), .o_err(s_err),
        .o_err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: mode 0/1/2 = hunting/checking/locked.
    int t = 0;
    int mode = 0;
    int start = 0;
    int good = 0;
    int bad = 0;
    int errs = 0;
    bit cur = 1'b0;
    bit e_hdr, e_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit sof, input bit fl);
        int words;
        bit due;
        e_hdr = 1'b0;
        e_err = 1'b0;
        words = cur ? RSBUS_LONG_LEN : RSBUS_SHORT_LEN;
        due = (t == start + words);
        if (mode == 0) begin
            start = t;
            cur = sof ? fl : 1'b0;
            if (sof) begin
                mode = 1;
                good = 1;
            end
        end else if (sof && due && fl != cur) begin
            start = t;
            cur = fl;
            bad = 0;
            if (mode == 1) begin
                good++;
                if (good == LOCK) mode = 2;
            end
            e_hdr = (mode == 2);
        end else if (sof || due) begin
            e_err = 1'b1;
            errs++;
            if (mode == 1) begin
                if (sof && !due) begin
                    start = t;
                    cur = fl;
                    good = 1;
                end else begin
                    mode = 0;
                    start = t;
                    cur = 1'b0;
                end
            end else begin
                bad++;
                if (due) begin
                    start = t;
                    cur = !cur;
                end
                if (bad == UNLOCK) begin
                    mode = 0;
                    bad = 0;
                end
            end
        end
    endtask

    task automatic step(input bit sof, input bit fl);
        rbus_word_t w;
        rbus_ctrl_t c;
        w = 16'($urandom);
        w.header.frm_len = fl;
        c = 8'($urandom);
        i_sof = sof;
        i_bus = w;
        i_ctrl = c;
        @(posedge clk);
        #1;
        model(sof, fl);
        chk("sof", o_sof, sof);
        chk("bus", o_bus, w);
        chk("ctrl", o_ctrl, c);
        chk("hdr_stb", o_hdr_stb, e_hdr);
        chk("frm_len", o_frm_len, cur);
        chk("word_idx", o_word_idx, t - start);
        chk("locked", o_locked, mode == 2);
        chk("err", o_err, e_err);
        chk("err_cnt", o_err_cnt, errs);
        chk("sat_cnt", s_err_cnt, (errs > 3) ? 3 : errs);
        t++;
    endtask

    task automatic mid_reset();
        #3 rst = 1'b0;
        #1;
        chk("rst_sof", o_sof, 0);
        chk("rst_hdr", o_hdr_stb, 0);
        chk("rst_lock", o_locked, 0);
        chk("rst_err", o_err, 0);
        chk("rst_cnt", o_err_cnt, 0);
        chk("rst_idx", o_word_idx, 0);
        chk("rst_len", o_frm_len, 0);
        chk("rst_flags", o_bus[15:11], 0);
        chk("rst_valid", o_ctrl.valid, 0);
        chk("rst_sat", s_err_cnt, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        mode = 0;
        start = t;
        cur = 1'b0;
        good = 0;
        bad = 0;
        errs = 0;
    endtask

    // Even n keeps frame 0 of every call short (frm_len 0).
    task automatic run_frames(input int n, input int drop_from,
                              input int drop_n, input int early_at,
                              input int bad_at, input int rst_at,
                              input int pct);
        bit fl, drop, early, lbad, s;
        int w;
        for (int k = 0; k < n; k++) begin
            fl = (k % 2) == 1;
            w = fl ? RSBUS_LONG_LEN : RSBUS_SHORT_LEN;
            drop = (k >= drop_from) && (k < drop_from + drop_n);
            early = (k == early_at);
            lbad = (k == bad_at);
            if (int'($urandom_range(99)) < pct) begin
                case ($urandom_range(2))
                    0: drop = 1'b1;
                    1: early = 1'b1;
                    default: lbad = 1'b1;
                endcase
            end
            for (int i = 0; i < w; i++) begin
                if (k == rst_at && i == 4) mid_reset();
                s = ((i == 0) && !drop) || ((i == w - 1) && early);
                step(s, (i == 0) ? (fl ^ lbad)
                                 : 1'($urandom_range(1)));
            end
        end
    endtask

    initial begin
        #12;
        chk("reset_sof", o_sof, 0);
        chk("reset_hdr", o_hdr_stb, 0);
        chk("reset_lock", o_locked, 0);
        chk("reset_err", o_err, 0);
        chk("reset_cnt", o_err_cnt, 0);
        chk("reset_idx", o_word_idx, 0);
        chk("reset_len", o_frm_len, 0);
        chk("reset_flags", o_bus[15:11], 0);
        chk("reset_valid", o_ctrl.valid, 0);
        #1 rst = 1'b1;

        run_frames(8, -1, 0, -1, -1, -1, 0);
        chk("clean_lock", o_locked, 1);
        chk("clean_cnt", o_err_cnt, 0);

        run_frames(4, -1, 0, 1, -1, -1, 0);
        chk("early_lock", o_locked, 1);
        chk("early_cnt", o_err_cnt, 1);

        run_frames(6, 1, 3, -1, -1, -1, 0);
        chk("drop_lock", o_locked, 0);
        chk("drop_cnt", o_err_cnt, 4);

        run_frames(8, -1, 0, -1, 4, -1, 0);
        chk("lenv_lock", o_locked, 1);
        chk("lenv_cnt", o_err_cnt, 5);
        chk("sat_at_3", s_err_cnt, 3);

        run_frames(4, -1, 0, -1, -1, 3, 0);
        chk("post_rst_lock", o_locked, 0);

        run_frames(6, -1, 0, -1, -1, -1, 0);
        chk("relock", o_locked, 1);
        chk("relock_cnt", o_err_cnt, 0);

        run_frames(40, -1, 0, -1, -1, -1, 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsbus_frame_checker.md
# rsbus_frame_checker

Receive-side companion of the ring-bus frame generator. It sits at the input of every ring node and watches the incoming `sof`/`ctrl`/`bus` stream. It locks onto the fixed 11-cycle slot pattern: a short frame of 2 words followed by a long frame of 9 words. Once locked, it outputs a registered copy of the stream plus per-frame timing (header strobe, word index, frame length), lock status and error statistics.

## Interface
- `LOCK_CNT`, default 4: consecutive good sofs needed to go from CHECK to LOCKED.
- `UNLOCK_CNT`, default 3: consecutive bad events in LOCKED that force HUNT.
- `ERR_W`, default 16: width of the error counter.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `i_sof`  in  1  start-of-frame marker from upstream.
- `i_ctrl`  in  `rbus_ctrl_t`  control word.
- `i_bus`  in  `rbus_word_t`  data word; the header is valid on the sof cycle.
- `o_sof`  out  1  registered copy of `i_sof`.
- `o_ctrl`  out  `rbus_ctrl_t`  registered copy of `i_ctrl`.
- `o_bus`  out  `rbus_word_t`  registered copy of `i_bus`.
- `o_hdr_stb`  out  1  header of an accepted frame is on `o_bus` this cycle.
- `o_frm_len`  out  1  length of the current frame: 0 = 2 words, 1 = 9 words.
- `o_word_idx`  out  4  word index inside the current frame; 0 on the header word.
- `o_locked`  out  1  state is LOCKED.
- `o_err`  out  1  one-cycle pulse per error event.
- `o_err_cnt`  out  `ERR_W`  saturating count of error events.

## Operation
- States:
  - HUNT: idle until the first sof.
  - CHECK: `i_sof` while in HUNT. Capture `len = i_bus.header.frm_len`, set `idx = 0`, `good = 1`.
  - LOCKED: `good` reaches `LOCK_CNT`.
- Expected length L: 2 if `len` = 0, 9 if `len` = 1. `idx` increments every cycle; a sof is expected when `idx == L-1` in the previous cycle.
- Good sof: it arrives on time and its `frm_len == !len_prev`; frame lengths must alternate.
- Error events, at most one per cycle, priority order:
  - early sof (`idx != L-1`);
  - missing sof (`idx == L-1` and no `i_sof` on the next expected cycle);
  - length violation (on-time sof with non-alternating `frm_len`).
- CHECK:
  - a good sof increments `good`;
  - any error sends the block to HUNT, except an early sof, which restarts CHECK on that sof with `good = 1`.
- LOCKED (flywheel):
  - the frame counter keeps running on the expected alternating pattern regardless of input;
  - each error increments `bad`, and the expected length is used instead of the received one;
  - a good sof clears `bad`;
  - `bad == UNLOCK_CNT` goes to HUNT.
- `o_hdr_stb` is asserted for a good sof whose post-update state is LOCKED; this includes the sof that completes the lock.
- `o_err_cnt` saturates at all-ones and is cleared only by reset.
- Errors are counted in CHECK and LOCKED, never in HUNT.

## Timing
- Every output is registered with one cycle of latency relative to the inputs. `o_hdr_stb`, `o_frm_len` and `o_word_idx` are aligned with `o_sof`/`o_bus`.
- Reset values:
  - `o_sof`, `o_hdr_stb`, `o_locked`, `o_err`, `o_frm_len`, `o_word_idx`: 0;
  - `o_err_cnt`: 0;
  - `o_ctrl.valid` and `o_bus.header` flag fields (`frm_used`, `frm_owned`, `frm_priority`, `frm_len`): 0;
  - remaining `ctrl`/`bus` fields are datapath-only and have no reset;
  - state HUNT, internal counters 0.
- Reset may be asserted mid-frame. It takes effect asynchronously, and the first sof after release starts CHECK.
- A missing sof is flagged in the cycle the sof was due. In LOCKED the frame boundary is still assumed in that cycle: `o_word_idx` returns to 0, `o_frm_len` toggles, and `o_hdr_stb` stays 0.
- Lock latency from HUNT with a clean stream: the first sof starts CHECK. `o_locked` rises one cycle after the `LOCK_CNT`-th good sof. With the default `LOCK_CNT` = 4, that is one cycle after the 4th sof.

## Structure
- Add to `rbus_pkg`:
  - `RSBUS_SHORT_LEN` = 2, `RSBUS_LONG_LEN` = 9, `RSBUS_PERIOD` = 11;
  - enum `rsbus_chk_state_t` {HUNT, CHECK, LOCKED}.
- The generator then uses the same constants.
- One sub-module, `rsbus_sat_counter` (parameterised width, increment, synchronous clear, saturate), instanced for `good`, `bad` and `o_err_cnt`.

## Test plan
- Clean generator stream after reset (sof at cycles 0, 2, 11, 13, 22, 24, …; `frm_len` 0, 1, 0, 1, …) -> `o_locked` = 1 one cycle after the 4th sof; `o_hdr_stb` on every sof from the 4th onward; `o_err_cnt` = 0.
- Locked, then one sof delivered 1 cycle early -> one `o_err` pulse, `o_err_cnt` = 1, `o_locked` stays 1; the next on-time sof clears `bad`.
- Locked, then three consecutive sofs suppressed -> `o_err` at each due cycle, `o_word_idx` keeps wrapping 0–1 / 0–8, `o_locked` falls after the 3rd error, `o_err_cnt` = 3.
- Locked, then `frm_len` = 1 on two consecutive sofs -> one length-violation error; `o_frm_len` follows the expected pattern; `o_hdr_stb` = 0 for that frame.
- `ERR_W` = 2 with 5 forced errors -> `o_err_cnt` saturates at 3.
- Reset asserted mid-long-frame while locked -> all outputs 0 immediately; after release, relock needs a full `LOCK_CNT` sequence.
